// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-path definitions: entry layout and bit timing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_rx_fifo_pkg;

  // One stored character: {frame_err, parity_err, data[7:0]}
  localparam int UART_ENTRY_W = 10;
  localparam int CHAR_BITS    = 10;   // start + 8 data + stop
  localparam int CLKS_PER_BIT = 420;

  typedef struct packed {
    logic       frame_err;
    logic       parity_err;
    logic [7:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Entry storage for the receive FIFO: DEPTH x 10-bit register array.
// Latency: write lands on the next clock edge; read is combinational.
// Backpressure: none; the caller decides when to write.
module uart_rx_fifo_mem
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                    clock,
  input  logic                    i_WrEn,
  input  logic [ADDR_W-1:0]       i_WrAddr,
  input  logic [UART_ENTRY_W-1:0] i_WrData,
  input  logic [ADDR_W-1:0]       i_RdAddr,
  output logic [UART_ENTRY_W-1:0] o_RdData
);

  // Storage is deliberately left unreset; the top gates the read port while empty.
  logic [UART_ENTRY_W-1:0] mem_q [DEPTH];

  // Synchronous write of one entry.
  always_ff @(posedge clock) begin
    if (i_WrEn) begin
      mem_q[i_WrAddr] <= i_WrData;
    end
  end

  assign o_RdData = mem_q[i_RdAddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures byte + error flags, FWFT valid/ready read port, level/threshold/overflow/timeout.
// Latency: a received byte is visible at the head one cycle after its data-ready pulse.
// Backpressure: none toward the receiver; a byte arriving at full without a same-cycle pop is dropped and flagged.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int TIMEOUT_CLKS = 4 * CHAR_BITS * CLKS_PER_BIT,
  parameter int TO_W         = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_DataReady,
  input  logic [7:0]        i_DataIn,
  input  logic              i_ParityError,
  input  logic              i_FrameError,
  output logic              o_Valid,
  input  logic              i_Ready,
  output logic [7:0]        o_Data,
  output logic              o_HeadParityErr,
  output logic              o_HeadFrameErr,
  output logic [ADDR_W:0]   o_Level,
  input  logic [ADDR_W:0]   i_Threshold,
  output logic              o_AboveThresh,
  output logic              o_Overflow,
  input  logic              i_ClearOverflow,
  input  logic              i_Flush,
  output logic              o_Timeout
);

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);
  localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TIMEOUT_CLKS);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              ovf_q, ovf_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              timeout_q, timeout_d;

  logic      valid, full, push, pop, ovf_set;
  rx_entry_t wr_entry, rd_entry;

  // Handshake decode; full/empty come from the registered level, so o_Valid never depends on i_Ready.
  always_comb begin
    valid   = (level_q != '0);
    full    = (level_q == FULL_LVL);
    pop     = valid & i_Ready & ~i_Flush;
    push    = i_DataReady & ~i_Flush & (~full | pop);
    ovf_set = i_DataReady & full & ~pop & ~i_Flush;
  end

  // Next-state for pointers, level, sticky overflow and the idle counter; flush overrides push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    if (i_Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + (ADDR_W+1)'(1);
        2'b01:   level_d = level_q - (ADDR_W+1)'(1);
        default: level_d = level_q;
      endcase
    end
    // Set beats clear when both happen together.
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (i_ClearOverflow) begin
      ovf_d = 1'b0;
    end
    if (push | pop | i_Flush | ~valid) begin
      cnt_d = '0;
    end else if (cnt_q != TO_MAX) begin
      cnt_d = cnt_q + TO_W'(1);
    end
    // Registered flag, computed from next state so it rises with the counter and drops on the pop edge.
    timeout_d = (cnt_d == TO_MAX) & (level_d != '0);
  end

  // State registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign wr_entry = '{frame_err: i_FrameError, parity_err: i_ParityError, data: i_DataIn};

  uart_rx_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clock    (clock),
    .i_WrEn   (push),
    .i_WrAddr (wr_ptr_q),
    .i_WrData (wr_entry),
    .i_RdAddr (rd_ptr_q),
    .o_RdData (rd_entry)
  );

  // Head fields are forced to zero while empty so stale storage never shows through.
  assign o_Valid         = valid;
  assign o_Data          = valid ? rd_entry.data : 8'h00;
  assign o_HeadParityErr = valid & rd_entry.parity_err;
  assign o_HeadFrameErr  = valid & rd_entry.frame_err;
  assign o_Level         = level_q;
  assign o_AboveThresh   = (i_Threshold != '0) & (level_q >= i_Threshold);
  assign o_Overflow      = ovf_q;
  assign o_Timeout       = timeout_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios then randomized traffic against a queue model.
// Latency: n/a.
// Backpressure: host ready is driven directly by the stimulus.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int TOUT  = 16800;

  logic       clock = 1'b0;
  logic       reset;
  logic       i_DataReady, i_ParityError, i_FrameError, i_Ready;
  logic [7:0] i_DataIn;
  logic [4:0] i_Threshold;
  logic       i_ClearOverflow, i_Flush;
  logic       o_Valid, o_HeadParityErr, o_HeadFrameErr, o_AboveThresh, o_Overflow, o_Timeout;
  logic [7:0] o_Data;
  logic [4:0] o_Level;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of {frame_err, parity_err, data}, sticky overflow bit, idle-cycle count.
  logic [9:0] mq[$];
  bit         m_ovf;
  int         m_idle;
  bit         m_to;

  always #5 clock = ~clock;

  uart_rx_fifo dut (
    .clock(clock), .reset(reset),
    .i_DataReady(i_DataReady), .i_DataIn(i_DataIn),
    .i_ParityError(i_ParityError), .i_FrameError(i_FrameError),
    .o_Valid(o_Valid), .i_Ready(i_Ready), .o_Data(o_Data),
    .o_HeadParityErr(o_HeadParityErr), .o_HeadFrameErr(o_HeadFrameErr),
    .o_Level(o_Level), .i_Threshold(i_Threshold), .o_AboveThresh(o_AboveThresh),
    .o_Overflow(o_Overflow), .i_ClearOverflow(i_ClearOverflow),
    .i_Flush(i_Flush), .o_Timeout(o_Timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: decide the transaction from the current inputs and model contents, advance, clear pulses.
  task automatic tick();
    int         sz;
    bit         f, do_pop, do_push, drop, busy;
    logic [9:0] ent;
    sz      = mq.size();
    f       = i_Flush;
    do_pop  = (sz > 0) && i_Ready && !f;
    do_push = i_DataReady && !f && ((sz < DEPTH) || do_pop);
    drop    = i_DataReady && (sz == DEPTH) && !do_pop && !f;
    busy    = do_push || do_pop || f || (sz == 0);
    ent     = {i_FrameError, i_ParityError, i_DataIn};
    @(posedge clock);
    #1;
    if (f) mq.delete();
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back(ent);
    if (drop) m_ovf = 1'b1;
    else if (i_ClearOverflow) m_ovf = 1'b0;
    if (busy) m_idle = 0;
    else if (m_idle < TOUT) m_idle++;
    m_to = (m_idle == TOUT) && (mq.size() != 0);
    i_DataReady     = 1'b0;
    i_Flush         = 1'b0;
    i_ClearOverflow = 1'b0;
  endtask

  task automatic check_model(input string tag);
    logic [9:0] h;
    bit         above;
    above = (i_Threshold != 5'd0) && (mq.size() >= int'(i_Threshold));
    chk({tag, "_valid"}, 32'(o_Valid), 32'(mq.size() != 0));
    chk({tag, "_level"}, 32'(o_Level), 32'(mq.size()));
    chk({tag, "_ovf"},   32'(o_Overflow), 32'(m_ovf));
    chk({tag, "_tout"},  32'(o_Timeout), 32'(m_to));
    chk({tag, "_above"}, 32'(o_AboveThresh), 32'(above));
    if (mq.size() != 0) begin
      h = mq[0];
      chk({tag, "_data"}, 32'(o_Data), 32'(h[7:0]));
      chk({tag, "_perr"}, 32'(o_HeadParityErr), 32'(h[8]));
      chk({tag, "_ferr"}, 32'(o_HeadFrameErr), 32'(h[9]));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(o_Valid), 32'd0);
    chk({tag, "_level"}, 32'(o_Level), 32'd0);
    chk({tag, "_above"}, 32'(o_AboveThresh), 32'd0);
    chk({tag, "_ovf"},   32'(o_Overflow), 32'd0);
    chk({tag, "_tout"},  32'(o_Timeout), 32'd0);
    chk({tag, "_data"},  32'(o_Data), 32'd0);
    chk({tag, "_perr"},  32'(o_HeadParityErr), 32'd0);
    chk({tag, "_ferr"},  32'(o_HeadFrameErr), 32'd0);
  endtask

  task automatic push_byte(input logic [7:0] d, input logic pe, input logic fe);
    i_DataReady = 1'b1; i_DataIn = d; i_ParityError = pe; i_FrameError = fe;
    tick();
  endtask

  task automatic pop_one();
    i_Ready = 1'b1;
    tick();
    i_Ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    i_DataReady = 0; i_DataIn = '0; i_ParityError = 0; i_FrameError = 0;
    i_Ready = 0; i_Threshold = 5'd4; i_ClearOverflow = 0; i_Flush = 0;
    m_ovf = 0; m_idle = 0; m_to = 0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("rst");
    #3 reset = 1'b1;
    @(posedge clock);
    #1;

    // 1: two plain bytes, then one pop
    push_byte(8'hA5, 0, 0);
    push_byte(8'h3C, 0, 0);
    chk("t1_level2", 32'(o_Level), 32'd2);
    chk("t1_headA5", 32'(o_Data), 32'hA5);
    pop_one();
    chk("t1_head3C", 32'(o_Data), 32'h3C);
    chk("t1_level1", 32'(o_Level), 32'd1);
    pop_one();
    check_model("t1_empty");

    // 2: error flags travel with their byte
    push_byte(8'h55, 1, 0);
    push_byte(8'h66, 0, 1);
    chk("t2_flags01", 32'({o_HeadFrameErr, o_HeadParityErr}), 32'b01);
    check_model("t2_first");
    pop_one();
    chk("t2_flags10", 32'({o_HeadFrameErr, o_HeadParityErr}), 32'b10);
    chk("t2_data66", 32'(o_Data), 32'h66);
    pop_one();

    // 3: fill, drop one at full, clear the sticky flag
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i), 1'($urandom), 1'($urandom));
    chk("t3_full", 32'(o_Level), 32'd16);
    push_byte(8'hFF, 0, 0);
    chk("t3_ovf_set", 32'(o_Overflow), 32'd1);
    chk("t3_level_held", 32'(o_Level), 32'd16);
    check_model("t3_drop");
    i_ClearOverflow = 1'b1;
    tick();
    chk("t3_ovf_clr", 32'(o_Overflow), 32'd0);

    // 4: push and pop together at full
    i_Ready = 1'b1;
    push_byte(8'h11, 0, 0);
    i_Ready = 1'b0;
    chk("t4_level16", 32'(o_Level), 32'd16);
    chk("t4_no_ovf", 32'(o_Overflow), 32'd0);
    for (int i = 0; i < DEPTH - 1; i++) begin
      check_model("t4_drain");
      pop_one();
    end
    chk("t4_last11", 32'(o_Data), 32'h11);
    pop_one();
    check_model("t4_empty");

    // 5: character timeout
    push_byte(8'h42, 0, 0);
    for (int k = 1; k <= TOUT; k++) begin
      tick();
      if (k == TOUT - 1) chk("t5_not_yet", 32'(o_Timeout), 32'd0);
    end
    chk("t5_timeout", 32'(o_Timeout), 32'd1);
    check_model("t5_model");
    pop_one();
    chk("t5_pop_clear", 32'(o_Timeout), 32'd0);

    // 6: threshold, flush with a concurrent byte, overflow survives flush
    i_Threshold = 5'd4;
    for (int i = 0; i < 3; i++) push_byte(8'($urandom), 0, 0);
    chk("t6_below", 32'(o_AboveThresh), 32'd0);
    push_byte(8'h04, 0, 0);
    chk("t6_above", 32'(o_AboveThresh), 32'd1);
    for (int i = 0; i < DEPTH - 3; i++) push_byte(8'($urandom), 0, 0);
    check_model("t6_ovf");
    i_Flush = 1'b1;
    push_byte(8'h99, 0, 0);
    chk("t6_flush_level", 32'(o_Level), 32'd0);
    chk("t6_flush_valid", 32'(o_Valid), 32'd0);
    chk("t6_flush_ovf", 32'(o_Overflow), 32'd1);
    check_model("t6_post");

    // Mid-fill asynchronous reset
    i_Threshold = 5'd2;
    for (int i = 0; i < 3; i++) push_byte(8'($urandom), 1, 1);
    check_model("rst2_pre");
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("rst2");
    mq.delete(); m_ovf = 0; m_idle = 0; m_to = 0;
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    check_model("rst2_post");

    // Randomized traffic: a slow-host phase that hits full, then a fast-host phase
    for (int n = 0; n < 800; n++) begin
      if (n % 32 == 0) i_Threshold = 5'($urandom_range(0, 16));
      i_DataReady     = 1'($urandom_range(0, 1));
      i_DataIn        = 8'($urandom);
      i_ParityError   = 1'($urandom);
      i_FrameError    = 1'($urandom);
      i_Ready         = (n < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      i_Flush         = ($urandom_range(0, 63) == 0);
      i_ClearOverflow = ($urandom_range(0, 15) == 0);
      tick();
      check_model("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
